// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row and column passes of a 2-D DCT.
// Rows are written into one bank while columns of the other bank are read out.
module dct_transpose_buf #(
  parameter int OUT_WIDTH = 16,
  parameter int N         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*OUT_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*OUT_WIDTH-1:0] out_data,
  output logic                   out_last
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // ready and valid are driven from registers only, so neither side
  // combinationally depends on the other.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  bank_state_t bank_state [2];
  bank_state_t bank_state_next [2];

  logic [1:0]           full;
  logic                 wbank;
  logic                 rbank;
  logic [2:0]           wrow;
  logic [2:0]           rcol;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 wr_done;
  logic                 rd_done;
  logic [OUT_WIDTH-1:0] mem [2][N][N];

  assign full      = {bank_state[1] == FULL, bank_state[0] == FULL};
  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign out_last  = out_valid && (rcol == 3'(N - 1));

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;
  assign wr_done = wr_fire && (wrow == 3'(N - 1));
  assign rd_done = rd_fire && (rcol == 3'(N - 1));

  // A write can only complete into an EMPTY bank and a read only out of a
  // FULL one, so a simultaneous set and clear always hit different banks.
  always_comb begin
    bank_state_next[0] = bank_state[0];
    bank_state_next[1] = bank_state[1];
    if (wr_done) bank_state_next[wbank] = FULL;
    if (rd_done) bank_state_next[rbank] = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      wbank         <= 1'b0;
      wrow          <= 3'd0;
      rbank         <= 1'b0;
      rcol          <= 3'd0;
    end else begin
      bank_state[0] <= bank_state_next[0];
      bank_state[1] <= bank_state_next[1];
      if (wr_fire) begin
        wrow <= wrow + 3'd1;
        if (wr_done) wbank <= !wbank;
      end
      if (rd_fire) begin
        rcol <= rcol + 3'd1;
        if (rd_done) rbank <= !rbank;
      end
    end
  end

  // Storage is not reset; the bank flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      for (int k = 0; k < N; k++) begin
        mem[wbank][wrow][k] <= in_data[k*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int r = 0; r < N; r++) begin
      out_data[r*OUT_WIDTH +: OUT_WIDTH] = mem[rbank][r][rcol];
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed and random-stall bench for dct_transpose_buf; expected columns
// come from a transposition of the generated row matrices.
module tb_dct_transpose_buf;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int DW = N * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  int checks;
  int failures;

  logic [DW-1:0] rows_q[$];
  logic [DW-1:0] exp_q[$];

  dct_transpose_buf #(.OUT_WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // element (r,c) of directed block b is b*256 + 16*r + c
  function automatic logic [DW-1:0] row_of(input int b, input int r);
    logic [DW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'(b*256 + 16*r + c);
    return v;
  endfunction

  function automatic logic [DW-1:0] col_of(input int b, input int c);
    logic [DW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++) v[r*W +: W] = W'(b*256 + 16*r + c);
    return v;
  endfunction

  task automatic write_block(input int b, input logic rdy);
    for (int r = 0; r < N; r++) begin
      in_valid  = 1'b1;
      in_data   = row_of(b, r);
      out_ready = rdy;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_block(input int b, input string tag);
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_col"}, out_data, col_of(b, c));
      chk({tag, "_last"}, out_last, c == N - 1);
      tick();
    end
    chk({tag, "_empty"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] m [N][N];
    logic [DW-1:0] v;
    logic wf;
    logic rf;
    int cyc;
    int ncol;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    rst = 1'b0;
    tick();

    // basic transpose: first column the cycle after row 7
    for (int r = 0; r < N; r++) begin
      chk("basic_in_ready", in_ready, 1'b1);
      chk("basic_no_out", out_valid, 1'b0);
      in_valid  = 1'b1;
      in_data   = row_of(0, r);
      out_ready = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain_block(0, "basic");

    // ping-pong: 3 blocks back to back, columns 8 cycles behind rows
    out_ready = 1'b1;
    for (int i = 0; i < 4 * N; i++) begin
      in_valid = (i < 3 * N);
      in_data  = row_of(1 + i / N, i % N);
      chk("pp_in_ready", in_ready, 1'b1);
      if (i < N) begin
        chk("pp_idle", out_valid, 1'b0);
      end else begin
        chk("pp_valid", out_valid, 1'b1);
        chk("pp_col", out_data, col_of(i / N, i % N));
        chk("pp_last", out_last, (i % N) == N - 1);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("pp_empty", out_valid, 1'b0);

    // backpressure: 16 rows fill both banks, then in_ready drops
    out_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      chk("bp_accept", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = row_of(4 + i / N, i % N);
      tick();
    end
    in_data = row_of(6, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_ready", in_ready, 1'b0);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_col0", out_data, col_of(4, 0));
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      chk("bp_ready_low", in_ready, 1'b0);
      chk("bp_col", out_data, col_of(4, c));
      tick();
    end
    in_valid = 1'b0;
    chk("bp_ready_rise", in_ready, 1'b1);
    drain_block(5, "bp2");

    // simultaneous write-complete and read-complete
    write_block(7, 1'b0);
    write_block(8, 1'b1);
    chk("sim_full", dut.full, 2'b10);
    chk("sim_rbank", dut.rbank, 1'b1);
    drain_block(8, "sim");

    // reset in the middle of a write block and a read block
    write_block(9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_data   = row_of(10, i);
      out_ready = (i < 3);
      tick();
    end
    out_ready = 1'b0;
    rst       = 1'b1;
    in_data   = row_of(12, 0);
    tick();
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_last", out_last, 1'b0);
    chk("mid_rst_full", dut.full, 2'b00);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_ignore_in", out_valid, 1'b0);
    write_block(11, 1'b0);
    drain_block(11, "fresh");

    // random stall with signed extremes
    for (int b = 0; b < 100; b++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          case ($urandom_range(0, 3))
            0:       m[r][c] = 16'h8000;
            1:       m[r][c] = 16'h7fff;
            default: m[r][c] = W'($urandom);
          endcase
        end
      end
      for (int r = 0; r < N; r++) begin
        v = '0;
        for (int c = 0; c < N; c++) v[c*W +: W] = m[r][c];
        rows_q.push_back(v);
      end
      for (int c = 0; c < N; c++) begin
        v = '0;
        for (int r = 0; r < N; r++) v[r*W +: W] = m[r][c];
        exp_q.push_back(v);
      end
    end
    cyc  = 0;
    ncol = 0;
    while (exp_q.size() > 0 && cyc < 20000) begin
      in_valid  = (rows_q.size() > 0) && ($urandom_range(0, 1) == 1);
      in_data   = (rows_q.size() > 0) ? rows_q[0] : '0;
      out_ready = ($urandom_range(0, 1) == 1);
      wf = in_valid && in_ready;
      rf = out_valid && out_ready;
      if (rf) begin
        chk("rand_col", out_data, exp_q.pop_front());
        chk("rand_last", out_last, (ncol % N) == N - 1);
        ncol++;
      end
      tick();
      if (wf) void'(rows_q.pop_front());
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand_all_cols", DW'(exp_q.size()), DW'(0));
    chk("rand_all_rows", DW'(rows_q.size()), DW'(0));
    chk("rand_end_empty", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dct_transpose_buf.md
DCT_TRANSPOSE_BUF -- requirements
Module: dct_transpose_buf

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 16, the width of one signed coefficient (the dct_pkg value).
REQ-002 SHALL have parameter N, default 8, the block dimension; only the value 8 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data holds one row of the first-pass 1-D DCT result.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a row this cycle.
REQ-007 SHALL have port in_data, input, N*OUT_WIDTH bits: signed coefficients; element k is at bits [k*OUT_WIDTH +: OUT_WIDTH].
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds one transposed column.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream second-pass stage accepts the column.
REQ-010 SHALL have port out_data, output, N*OUT_WIDTH bits: column c, with element r equal to row r, element c, in the same packing as in_data.
REQ-011 SHALL have port out_last, output, 1 bit: high with out_valid when the column index is N-1.

Function
REQ-012 SHALL store data in two 8x8 banks (ping-pong); a write transfer is in_valid && in_ready; a read transfer is out_valid && out_ready.
REQ-013 SHALL keep these registers:
- wbank (1 bit), wrow (3 bits): the bank and row being written.
- rbank (1 bit), rcol (3 bits): the bank and column being read.
- full[1:0]: one flag per bank.
REQ-014 SHALL treat each bank as a 2-state machine, EMPTY (full=0) or FULL (full=1):
- EMPTY -> FULL on the write transfer with wrow==7.
- FULL -> EMPTY on the read transfer with rcol==7.
REQ-015 On a write transfer, SHALL store in_data row wrow of bank wbank and increment wrow.
- When wrow wraps 7->0, it SHALL set full[wbank] and toggle wbank.
REQ-016 SHALL drive in_ready = !full[wbank], combinationally from registers, with no dependence on in_valid.
REQ-017 SHALL drive out_valid = full[rbank], combinationally from registers, with no dependence on out_ready.
REQ-018 On a read transfer, SHALL increment rcol.
- When rcol wraps 7->0, it SHALL clear full[rbank] and toggle rbank.
REQ-019 SHALL drive out_data as column rcol of bank rbank; it SHALL stay stable while out_valid && !out_ready.
REQ-020 Latency: the first column SHALL be valid in the cycle after the write transfer of row 7; no bubble is allowed between columns while out_ready=1.
REQ-021 A write-complete and a read-complete in the same cycle SHALL both take effect, set and clear acting on different banks.
REQ-022 With both banks FULL, SHALL hold in_ready=0 until the read bank drains.
- in_ready SHALL rise in the cycle after the read transfer of column 7.
REQ-023 Sustained throughput SHALL be one row in and one column out per cycle with no stall.
REQ-024 Data SHALL pass bit-exact: no rounding, saturation or sign change.

Reset
REQ-025 While rst=1 at a clock edge, SHALL clear wbank, wrow, rbank, rcol and full.
- Outputs after that edge: in_ready=1, out_valid=0, out_last=0.
REQ-026 Reset mid-block SHALL discard every partially written and partially read block; bank storage need not be reset.
REQ-027 While rst=1, in_valid SHALL be ignored.

Verification
REQ-028 Basic transpose: reset, then 8 rows with element (r,c) = 16*r + c and out_ready=1 -> 8 columns starting the cycle after row 7.
- Column c element r = 16*r + c.
- out_last high only on column 7.
REQ-029 Ping-pong back-to-back: 3 blocks streamed with in_valid=1 and out_ready=1 throughout.
- in_ready stays 1.
- Columns of block k begin 8 cycles after block k's first row is accepted.
REQ-030 Backpressure: out_ready=0 with 16 rows offered.
- 16 rows are accepted, then in_ready=0.
- out_data stays at column 0 of block 0.
- After out_ready=1, in_ready rises the cycle after the 8th column transfer.
REQ-031 Random stall: in_valid and out_ready toggled at random (50%), 100 blocks with signed extremes -32768 and 32767.
- Scoreboard matches every transposed value with no loss or duplication.
REQ-032 Reset mid-operation: rst=1 after 5 rows of block 0 and 3 columns of an earlier full block.
- Next cycle: in_ready=1, out_valid=0.
- A fresh 8-row block then transposes correctly from row 0.
REQ-033 Simultaneous events: row 7 of block 1 written in the same cycle as column 7 of block 0 is read.
- full becomes 2'b10 (bank 1 full, bank 0 empty).
- rbank=1, out_valid=1 with column 0 of block 1.
